// File: rtl/mult_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_seq_pkg                                                         |
// | State encoding and per-phase shift helpers for the sequenced         |
// | W x W multiplier controller.                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mult_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ALBL = 3'd1,
    ALBH = 3'd2,
    AHBL = 3'd3,
    AHBH = 3'd4,
    DONE = 3'd5
  } mult_seq_e;

  // Shift applied to each partial product, in units of HALF_W
  localparam int unsigned SH_ALBL = 0;
  localparam int unsigned SH_ALBH = 1;
  localparam int unsigned SH_AHBL = 1;
  localparam int unsigned SH_AHBH = 2;

  function automatic int unsigned phase_shift_halves(input mult_seq_e s);
    case (s)
      ALBL:    return SH_ALBL;
      ALBH:    return SH_ALBH;
      AHBL:    return SH_AHBL;
      AHBH:    return SH_AHBH;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_seq_ctrl_if                                                     |
// | Issue-side and writeback-side handshake bundle of the controller.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mult_seq_ctrl_if #(parameter int W = 32);

  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] op_a_i;
  logic [W-1:0] op_b_i;
  logic         op_hi_i;
  logic         flush_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] result_o;
  logic         busy_o;

  // Issue / writeback side
  modport master (
    output in_valid_i, op_a_i, op_b_i, op_hi_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );

  // Controller side
  modport slave (
    input  in_valid_i, op_a_i, op_b_i, op_hi_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/mult_seq_ctrl_half.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_half                                                            |
// | Combinational HALF_W x HALF_W unsigned multiplier shared by all      |
// | phases of the sequencer.                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mult_half #(
  parameter int HALF_W = 16
) (
  input  wire logic [HALF_W-1:0]   a,
  input  wire logic [HALF_W-1:0]   b,
  output logic      [2*HALF_W-1:0] p
);

  // Full-width product; never overflows 2*HALF_W bits
  always_comb begin
    p = a * b;
  end

endmodule
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_seq_ctrl                                                        |
// | Sequences four partial products through one half-width multiplier   |
// | and returns the low or high half of the W x W product.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int W = 32
) (
  input wire logic       clk_i,
  input wire logic       rst_i,
  mult_seq_ctrl_if.slave bus
);

  localparam int HALF_W = W / 2;

  mult_seq_e         state;
  mult_seq_e         state_nxt;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              op_hi;
  logic [2*W-1:0]    acc;
  logic [2*W-1:0]    acc_sum;
  logic [2*W-1:0]    addend;
  logic [W-1:0]      result;
  logic [HALF_W-1:0] mul_a;
  logic [HALF_W-1:0] mul_b;
  logic [W-1:0]      prod;
  logic              accept;
  logic              compute;

  mult_half #(.HALF_W(HALF_W)) u_mult_half (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // State, operand, accumulator and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      op_hi  <= 1'b0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a  <= bus.op_a_i;
        op_b  <= bus.op_b_i;
        op_hi <= bus.op_hi_i;
        acc   <= '0;
      end else if (compute && !bus.flush_i) begin
        acc <= acc_sum;
      end
      // Capture the selected half on the final accumulate, as DONE is entered
      if (compute && state_nxt == DONE) begin
        result <= op_hi ? acc_sum[2*W-1:W] : acc_sum[W-1:0];
      end
    end
  end

  // Next-state: flush wins over every handshake; stray encodings recover to IDLE
  always_comb begin
    state_nxt = state;
    if (bus.flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid_i) state_nxt = ALBL;
        ALBL:    state_nxt = ALBH;
        ALBH:    state_nxt = AHBL;
        AHBL:    state_nxt = op_hi ? AHBH : DONE;  // high partial cannot touch low half
        AHBH:    state_nxt = DONE;
        DONE:    if (bus.out_ready_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand mux, shifted accumulate and handshake outputs, all decoded from state
  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    compute = 1'b0;
    case (state)
      ALBL: begin mul_a = op_a[HALF_W-1:0]; mul_b = op_b[HALF_W-1:0]; compute = 1'b1; end
      ALBH: begin mul_a = op_a[HALF_W-1:0]; mul_b = op_b[W-1:HALF_W]; compute = 1'b1; end
      AHBL: begin mul_a = op_a[W-1:HALF_W]; mul_b = op_b[HALF_W-1:0]; compute = 1'b1; end
      AHBH: begin mul_a = op_a[W-1:HALF_W]; mul_b = op_b[W-1:HALF_W]; compute = 1'b1; end
      default: ;
    endcase
    addend  = {{W{1'b0}}, prod} << (phase_shift_halves(state) * HALF_W);
    // Carry out of the top bit cannot occur for a true W x W product
    acc_sum = acc + addend;
    accept  = (state == IDLE) && bus.in_valid_i && !bus.flush_i;

    bus.in_ready_o  = (state == IDLE);
    bus.busy_o      = (state != IDLE);
    bus.out_valid_o = (state == DONE);
    bus.result_o    = result;
  end

endmodule
`default_nettype wire
